// File: rtl/cache_flush_ctrl_pkg.sv
// Shared state encodings and sizing constants for the cache flush engine.
package cache_flush_ctrl_pkg;

   localparam int L1_NUM_SETS = 256;
   localparam int FLUSH_WORDS = 4;

   typedef enum logic [2:0] {
      FLUSH_IDLE  = 3'd0,
      FLUSH_CHECK = 3'd1,
      FLUSH_WB    = 3'd2,
      FLUSH_CLEAN = 3'd3,
      FLUSH_DONE  = 3'd4
   } flush_state_e;

endpackage

// File: rtl/cache_flush_ctrl_line_buf.sv
// Capture register for one dirty line (tag plus four data words) with a word-select read mux.
module flush_line_buf
   import cache_flush_ctrl_pkg::*;
#(
   parameter int WORD_W = 16,
   parameter int TAG_W  = 5
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [TAG_W-1:0]  tag_in,
   input  logic [WORD_W-1:0] data_in0,
   input  logic [WORD_W-1:0] data_in1,
   input  logic [WORD_W-1:0] data_in2,
   input  logic [WORD_W-1:0] data_in3,
   input  logic [1:0]        word_sel,
   output logic [TAG_W-1:0]  tag_out,
   output logic [WORD_W-1:0] word_out
);

   logic [TAG_W-1:0]  tag_q;
   logic [WORD_W-1:0] data_q [FLUSH_WORDS];

   // Line capture register
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_q <= '0;
         for (int i = 0; i < FLUSH_WORDS; i++) begin
            data_q[i] <= '0;
         end
      end else if (load) begin
         tag_q     <= tag_in;
         data_q[0] <= data_in0;
         data_q[1] <= data_in1;
         data_q[2] <= data_in2;
         data_q[3] <= data_in3;
      end else begin
         tag_q <= tag_q;
         for (int i = 0; i < FLUSH_WORDS; i++) begin
            data_q[i] <= data_q[i];
         end
      end
   end

   // Word-select read mux
   always_comb begin
      word_out = '0;
      case (word_sel)
         2'd0:    word_out = data_q[0];
         2'd1:    word_out = data_q[1];
         2'd2:    word_out = data_q[2];
         2'd3:    word_out = data_q[3];
         default: word_out = '0;
      endcase
   end

   assign tag_out = tag_q;

endmodule

// File: rtl/cache_flush_ctrl.sv
// Flush engine that walks every cache set, writes back dirty lines and clears their dirty bit.
// Build option CACHE_FLUSH_INVALIDATE_EN also clears the valid bit of every valid set.
module cache_flush_ctrl
   import cache_flush_ctrl_pkg::*;
#(
   parameter int NUM_SETS = L1_NUM_SETS,
   parameter int IDX_W    = 8,
   parameter int TAG_W    = 5,
   parameter int WORD_W   = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_req,
   output logic              flush_busy,
   output logic              flush_done,
   output logic [IDX_W-1:0]  arr_addr,
   input  logic              valid_rd,
   input  logic              dirty_rd,
   input  logic [TAG_W-1:0]  tag_rd,
   input  logic [WORD_W-1:0] data_rd0,
   input  logic [WORD_W-1:0] data_rd1,
   input  logic [WORD_W-1:0] data_rd2,
   input  logic [WORD_W-1:0] data_rd3,
   output logic              dirty_write,
   output logic              dirty_wdata,
   output logic              valid_write,
   output logic              valid_wdata,
   output logic              mem_req,
   output logic [15:0]       mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic              mem_ack
);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SETS - 1);
   localparam logic [1:0]       LAST_WORD = 2'(FLUSH_WORDS - 1);

   flush_state_e      state_q, state_d;
   logic [IDX_W-1:0]  index_q, index_d;
   logic [1:0]        word_q, word_d;
   logic              mem_req_q, mem_req_d;
   logic [15:0]       mem_addr_q, mem_addr_d;
   logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;

   logic              buf_load_s;
   logic [1:0]        word_inc_s;
   logic [TAG_W-1:0]  buf_tag_s;
   logic [WORD_W-1:0] buf_word_s;

   assign word_inc_s = word_q + 2'd1;

   flush_line_buf #(
      .WORD_W (WORD_W),
      .TAG_W  (TAG_W)
   ) u_line_buf (
      .clk      (clk),
      .rst      (rst),
      .load     (buf_load_s),
      .tag_in   (tag_rd),
      .data_in0 (data_rd0),
      .data_in1 (data_rd1),
      .data_in2 (data_rd2),
      .data_in3 (data_rd3),
      .word_sel (word_inc_s),
      .tag_out  (buf_tag_s),
      .word_out (buf_word_s)
   );

   // Next-state, counters and next memory request
   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      word_d      = word_q;
      buf_load_s  = 1'b0;
      mem_req_d   = 1'b0;
      mem_addr_d  = 16'h0000;
      mem_wdata_d = '0;
      case (state_q)
         FLUSH_IDLE: begin
            if (flush_req) begin
               state_d = FLUSH_CHECK;
               index_d = '0;
            end else begin
               state_d = FLUSH_IDLE;
            end
         end
         FLUSH_CHECK: begin
            if (valid_rd && dirty_rd) begin
               // First word goes out straight from the array so the request is live on WB entry
               buf_load_s  = 1'b1;
               word_d      = 2'd0;
               state_d     = FLUSH_WB;
               mem_req_d   = 1'b1;
               mem_addr_d  = 16'({tag_rd, index_q, 2'd0, 1'b0});
               mem_wdata_d = data_rd0;
            end
`ifdef CACHE_FLUSH_INVALIDATE_EN
            else if (valid_rd) begin
               state_d = FLUSH_CLEAN;
            end
`endif
            else if (index_q == LAST_IDX) begin
               state_d = FLUSH_DONE;
            end else begin
               index_d = index_q + {{(IDX_W-1){1'b0}}, 1'b1};
            end
         end
         FLUSH_WB: begin
            if (mem_ack) begin
               if (word_q == LAST_WORD) begin
                  state_d = FLUSH_CLEAN;
               end else begin
                  word_d      = word_inc_s;
                  mem_req_d   = 1'b1;
                  mem_addr_d  = 16'({buf_tag_s, index_q, word_inc_s, 1'b0});
                  mem_wdata_d = buf_word_s;
               end
            end else begin
               mem_req_d   = 1'b1;
               mem_addr_d  = mem_addr_q;
               mem_wdata_d = mem_wdata_q;
            end
         end
         FLUSH_CLEAN: begin
            if (index_q == LAST_IDX) begin
               state_d = FLUSH_DONE;
            end else begin
               index_d = index_q + {{(IDX_W-1){1'b0}}, 1'b1};
               state_d = FLUSH_CHECK;
            end
         end
         FLUSH_DONE: begin
            state_d = FLUSH_IDLE;
         end
         default: begin
            state_d = FLUSH_IDLE;
         end
      endcase
   end

   // State, counters and registered memory port
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FLUSH_IDLE;
         index_q     <= '0;
         word_q      <= 2'd0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= 16'h0000;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         word_q      <= word_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Strobes are masked by rst so an aborted flush never writes the arrays or signals completion
   assign flush_busy  = (state_q != FLUSH_IDLE);
   assign flush_done  = (state_q == FLUSH_DONE) && !rst;
   assign arr_addr    = ((state_q == FLUSH_CHECK) || (state_q == FLUSH_CLEAN)) ? index_q : '0;
   assign dirty_write = (state_q == FLUSH_CLEAN) && !rst;
   assign dirty_wdata = 1'b0;
`ifdef CACHE_FLUSH_INVALIDATE_EN
   assign valid_write = (state_q == FLUSH_CLEAN) && !rst;
`else
   assign valid_write = 1'b0;
`endif
   assign valid_wdata = 1'b0;
   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Directed bench for cache_flush_ctrl with a behavioural model of the memc arrays and a memory responder.
module tb_cache_flush_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_req;
   logic        flush_busy, flush_done;
   logic [7:0]  arr_addr;
   logic        valid_rd, dirty_rd;
   logic [4:0]  tag_rd;
   logic [15:0] data_rd0, data_rd1, data_rd2, data_rd3;
   logic        dirty_write, dirty_wdata, valid_write, valid_wdata;
   logic        mem_req;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_ack = 1'b0;

   always #5 clk = ~clk;

   cache_flush_ctrl dut (
      .clk (clk), .rst (rst), .flush_req (flush_req),
      .flush_busy (flush_busy), .flush_done (flush_done), .arr_addr (arr_addr),
      .valid_rd (valid_rd), .dirty_rd (dirty_rd), .tag_rd (tag_rd),
      .data_rd0 (data_rd0), .data_rd1 (data_rd1), .data_rd2 (data_rd2), .data_rd3 (data_rd3),
      .dirty_write (dirty_write), .dirty_wdata (dirty_wdata),
      .valid_write (valid_write), .valid_wdata (valid_wdata),
      .mem_req (mem_req), .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_ack (mem_ack)
   );

   // memc array model: combinational read, returns 0 while written
   logic        valid_arr [0:255];
   logic        dirty_arr [0:255];
   logic [4:0]  tag_arr   [0:255];
   logic [15:0] data_arr  [0:255][0:3];
   logic        clr_all = 1'b0, set_en = 1'b0, set_v, set_d;
   logic [7:0]  set_idx;
   logic [4:0]  set_tag;
   logic [15:0] set_w0, set_w1, set_w2, set_w3;

   assign valid_rd = valid_write ? 1'b0 : valid_arr[arr_addr];
   assign dirty_rd = dirty_write ? 1'b0 : dirty_arr[arr_addr];
   assign tag_rd   = tag_arr[arr_addr];
   assign data_rd0 = data_arr[arr_addr][0];
   assign data_rd1 = data_arr[arr_addr][1];
   assign data_rd2 = data_arr[arr_addr][2];
   assign data_rd3 = data_arr[arr_addr][3];

   int cyc = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (clr_all) begin
         for (int i = 0; i < 256; i++) begin
            valid_arr[i] <= 1'b0; dirty_arr[i] <= 1'b0; tag_arr[i] <= 5'd0;
            for (int j = 0; j < 4; j++) data_arr[i][j] <= 16'h0000;
         end
      end else if (set_en) begin
         valid_arr[set_idx] <= set_v; dirty_arr[set_idx] <= set_d; tag_arr[set_idx] <= set_tag;
         data_arr[set_idx][0] <= set_w0; data_arr[set_idx][1] <= set_w1;
         data_arr[set_idx][2] <= set_w2; data_arr[set_idx][3] <= set_w3;
      end else begin
         if (dirty_write) dirty_arr[arr_addr] <= dirty_wdata;
         if (valid_write) valid_arr[arr_addr] <= valid_wdata;
      end
   end

   // Memory responder and event recorder, sampling on the falling edge
   int          ack_delay = 0, wait_cnt = 0;
   int          req_cnt = 0, dw_cnt = 0, vw_cnt = 0, done_cnt = 0, done_cyc = 0, stab_err = 0, ack_n = 0;
   logic [7:0]  dw_addr = 8'd0, vw_addr = 8'd0;
   logic        prev_req = 1'b0, prev_ack = 1'b0;
   logic [15:0] prev_addr = 16'h0, prev_data = 16'h0;
   logic [15:0] ack_addr_log [0:63];
   logic [15:0] ack_data_log [0:63];

   always @(negedge clk) begin
      if (mem_req) begin
         req_cnt <= req_cnt + 1;
         if (prev_req && !prev_ack && (mem_addr !== prev_addr || mem_wdata !== prev_data))
            stab_err <= stab_err + 1;
         if (wait_cnt >= ack_delay) begin
            mem_ack <= 1'b1;
            wait_cnt <= 0;
            if (ack_n < 64) begin
               ack_addr_log[ack_n] <= mem_addr;
               ack_data_log[ack_n] <= mem_wdata;
            end
            ack_n <= ack_n + 1;
         end else begin
            mem_ack <= 1'b0;
            wait_cnt <= wait_cnt + 1;
         end
      end else begin
         mem_ack <= 1'b0;
         wait_cnt <= 0;
      end
      prev_req  <= mem_req;
      prev_ack  <= mem_req && (wait_cnt >= ack_delay);
      prev_addr <= mem_addr;
      prev_data <= mem_wdata;
      if (dirty_write) begin dw_cnt <= dw_cnt + 1; dw_addr <= arr_addr; end
      if (valid_write) begin vw_cnt <= vw_cnt + 1; vw_addr <= arr_addr; end
      if (flush_done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
   end

   int n_chk = 0, n_fail = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_arrays();
      clr_all = 1'b1; step(); clr_all = 1'b0;
   endtask

   task automatic set_line(input logic [7:0] idx, input logic v, input logic d, input logic [4:0] tg,
                           input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3);
      set_idx = idx; set_v = v; set_d = d; set_tag = tg;
      set_w0 = w0; set_w1 = w1; set_w2 = w2; set_w3 = w3;
      set_en = 1'b1; step(); set_en = 1'b0;
   endtask

   task automatic start_flush(input string tag, output int rc);
      flush_req = 1'b1;
      rc = cyc;
      @(negedge clk);
      check_val({tag, "_busy_pre"}, flush_busy, 1'b0);
      step();
      flush_req = 1'b0;
      @(negedge clk);
      check_val({tag, "_busy_run"}, flush_busy, 1'b1);
   endtask

   task automatic wait_done(input string tag, input int base_done);
      for (int i = 0; i < 4000; i++) begin
         step();
         if (done_cnt != base_done) break;
      end
      check_val({tag, "_done_seen"}, (done_cnt != base_done), 1'b1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_busy"},  flush_busy,  1'b0);
      check_val({tag, "_done"},  flush_done,  1'b0);
      check_val({tag, "_addr"},  arr_addr,    8'd0);
      check_val({tag, "_dw"},    dirty_write, 1'b0);
      check_val({tag, "_vw"},    valid_write, 1'b0);
      check_val({tag, "_req"},   mem_req,     1'b0);
      check_val({tag, "_maddr"}, mem_addr,    16'h0000);
      check_val({tag, "_mdata"}, mem_wdata,   16'h0000);
   endtask

   int rc, b_req, b_dw, b_vw, b_done, b_ack, b_stab;

   task automatic snap();
      b_req = req_cnt; b_dw = dw_cnt; b_vw = vw_cnt; b_done = done_cnt; b_ack = ack_n; b_stab = stab_err;
   endtask

   initial begin
      rst = 1'b1; flush_req = 1'b0;
      clr_all = 1'b1; step(); step(); clr_all = 1'b0;
      step();
      check_outputs_zero("reset");
      rst = 1'b0;
      step();
      check_outputs_zero("idle");

      // All sets invalid
      snap();
      start_flush("t1", rc);
      wait_done("t1", b_done);
      check_val("t1_done_lat", done_cyc - rc, 257);
      check_val("t1_req_cnt", req_cnt - b_req, 0);
      check_val("t1_dw_cnt",  dw_cnt - b_dw, 0);
      check_val("t1_vw_cnt",  vw_cnt - b_vw, 0);
      step();
      check_val("t1_busy_after", flush_busy, 1'b0);

      // Set 5 dirty, immediate ack
      set_line(8'd5, 1'b1, 1'b1, 5'h1A, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
      ack_delay = 0; snap();
      start_flush("t2", rc);
      wait_done("t2", b_done);
      check_val("t2_done_lat", done_cyc - rc, 262);
      check_val("t2_acks", ack_n - b_ack, 4);
      check_val("t2_req_cnt", req_cnt - b_req, 4);
      for (int w = 0; w < 4; w++) begin
         check_val($sformatf("t2_addr%0d", w), ack_addr_log[b_ack + w], 16'hD028 + 16'(2 * w));
         check_val($sformatf("t2_data%0d", w), ack_data_log[b_ack + w], 16'h1111 * 16'(w + 1));
      end
      check_val("t2_dw_cnt", dw_cnt - b_dw, 1);
      check_val("t2_dw_addr", dw_addr, 8'd5);
      check_val("t2_dirty5", dirty_arr[5], 1'b0);

      // Set 5 dirty, ack held off 3 cycles per word
      clear_arrays();
      set_line(8'd5, 1'b1, 1'b1, 5'h1A, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
      ack_delay = 3; snap();
      start_flush("t3", rc);
      wait_done("t3", b_done);
      check_val("t3_done_lat", done_cyc - rc, 274);
      check_val("t3_acks", ack_n - b_ack, 4);
      check_val("t3_req_cnt", req_cnt - b_req, 16);
      check_val("t3_stable", stab_err - b_stab, 0);
      check_val("t3_addr3", ack_addr_log[b_ack + 3], 16'hD02E);
      check_val("t3_data2", ack_data_log[b_ack + 2], 16'h3333);
      check_val("t3_dw_cnt", dw_cnt - b_dw, 1);

      // Sets 0 and 255 dirty, extra request while busy
      clear_arrays();
      set_line(8'd0,   1'b1, 1'b1, 5'h03, 16'hA000, 16'hA001, 16'hA002, 16'hA003);
      set_line(8'd255, 1'b1, 1'b1, 5'h1F, 16'hB000, 16'hB001, 16'hB002, 16'hB003);
      ack_delay = 0; snap();
      start_flush("t4", rc);
      for (int i = 0; i < 10; i++) step();
      flush_req = 1'b1; step(); flush_req = 1'b0;
      wait_done("t4", b_done);
      check_val("t4_done_lat", done_cyc - rc, 267);
      check_val("t4_acks", ack_n - b_ack, 8);
      check_val("t4_addr0", ack_addr_log[b_ack], 16'h1800);
      check_val("t4_data1", ack_data_log[b_ack + 1], 16'hA001);
      check_val("t4_addr4", ack_addr_log[b_ack + 4], 16'hFFF8);
      check_val("t4_addr7", ack_addr_log[b_ack + 7], 16'hFFFE);
      check_val("t4_data7", ack_data_log[b_ack + 7], 16'hB003);
      check_val("t4_dw_cnt", dw_cnt - b_dw, 2);
      check_val("t4_dw_last", dw_addr, 8'd255);
      for (int i = 0; i < 5; i++) step();
      check_val("t4_one_done", done_cnt - b_done, 1);
      check_val("t4_idle", flush_busy, 1'b0);

      // Reset during write-back of set 5, then restart
      clear_arrays();
      set_line(8'd5, 1'b1, 1'b1, 5'h1A, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
      ack_delay = 2; snap();
      start_flush("t5", rc);
      for (int i = 0; i < 400; i++) begin
         if (mem_req) break;
         step();
      end
      check_val("t5_wb_seen", mem_req, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check_val("t5_rst_dw", dirty_write, 1'b0);
      step();
      rst = 1'b0;
      check_outputs_zero("t5_abort");
      step();
      check_val("t5_no_done", done_cnt - b_done, 0);
      check_val("t5_no_dw", dw_cnt - b_dw, 0);
      check_val("t5_dirty5_kept", dirty_arr[5], 1'b1);
      ack_delay = 0; snap();
      start_flush("t5r", rc);
      wait_done("t5r", b_done);
      check_val("t5r_done_lat", done_cyc - rc, 262);
      check_val("t5r_addr0", ack_addr_log[b_ack], 16'hD028);
      check_val("t5r_acks", ack_n - b_ack, 4);
      check_val("t5r_dirty5", dirty_arr[5], 1'b0);

      // Set 7 valid but clean
      clear_arrays();
      set_line(8'd7, 1'b1, 1'b0, 5'h07, 16'h7000, 16'h7001, 16'h7002, 16'h7003);
      snap();
      start_flush("t6", rc);
      wait_done("t6", b_done);
      check_val("t6_req_cnt", req_cnt - b_req, 0);
`ifdef CACHE_FLUSH_INVALIDATE_EN
      check_val("t6_done_lat", done_cyc - rc, 258);
      check_val("t6_vw_cnt", vw_cnt - b_vw, 1);
      check_val("t6_dw_cnt", dw_cnt - b_dw, 1);
      check_val("t6_vw_addr", vw_addr, 8'd7);
      check_val("t6_dw_addr", dw_addr, 8'd7);
      check_val("t6_valid7", valid_arr[7], 1'b0);
`else
      check_val("t6_done_lat", done_cyc - rc, 257);
      check_val("t6_vw_cnt", vw_cnt - b_vw, 0);
      check_val("t6_dw_cnt", dw_cnt - b_dw, 0);
      check_val("t6_valid7", valid_arr[7], 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cache_flush_ctrl.md
Name: cache_flush_ctrl

Overview:
- Sequential flush engine placed beside one L1 cache instance.
- Owns the cache-array address port while busy and walks every set.
- Dirty+valid lines are written back to main memory as four 16-bit words, then their dirty bit is cleared.
- It drives the memc arrays' addr/write/data_in and consumes their combinational data_out, so it sits directly up/downstream of the tag, valid, dirty and data arrays.

Parameters:
- NUM_SETS, 256, sets walked; index width is log2(NUM_SETS).
- IDX_W, 8, set index width.
- TAG_W, 5, tag width.
- WORD_W, 16, data word width.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- flush_req  input  1  start pulse; sampled only in IDLE.
- flush_busy  output  1  high from the cycle after an accepted request through DONE; the cache controller must not touch the arrays while it is high.
- flush_done  output  1  one-cycle pulse at completion.
- arr_addr  output  IDX_W  index driven to all memc arrays.
- valid_rd  input  1  valid array data_out.
- dirty_rd  input  1  dirty array data_out.
- tag_rd  input  TAG_W  tag array data_out.
- data_rd0..data_rd3  input  WORD_W each  data arrays 0..3 data_out.
- dirty_write  output  1  dirty array write strobe.
- dirty_wdata  output  1  dirty array data_in; always 0.
- valid_write  output  1  valid array write strobe (see Optional Feature).
- valid_wdata  output  1  valid array data_in; always 0.
- mem_req  output  1  memory write request.
- mem_addr  output  16  byte address {tag, index, word, 1'b0}.
- mem_wdata  output  WORD_W  write data.
- mem_ack  input  1  memory accepts the current word.

Behaviour:
- Reset: state IDLE, index 0, word 0. All outputs 0 (flush_busy, flush_done, arr_addr, dirty_write, valid_write, mem_req, mem_addr, mem_wdata).
- Reset mid-flush aborts immediately: no done pulse, and no array writes in that cycle.
- Array reads are combinational. memc returns 0 while its write is high, so reads and writes are never issued in the same cycle.
- States: IDLE, CHECK, WB, CLEAN, DONE.
- IDLE: on flush_req, go to CHECK with index=0. A flush_req in any other state is ignored.
- CHECK: arr_addr=index.
  - If valid_rd & dirty_rd: capture tag_rd and data_rd0..3 into the line buffer, word=0, go to WB.
  - Otherwise: if index==NUM_SETS-1 go to DONE, else index++ and stay in CHECK. This costs 1 cycle per clean set.
- WB: mem_req=1, mem_addr={tag_q, index, word, 1'b0}, mem_wdata=buf[word]. Address and data stay stable until mem_ack.
  - On mem_ack: if word==3 go to CLEAN, else word++.
  - An ack on the same cycle mem_req first rises counts.
  - mem_ack outside WB is ignored.
- CLEAN: arr_addr=index, dirty_write=1 for exactly one cycle. Then go to DONE if index==NUM_SETS-1, else index++ and go to CHECK.
- DONE: flush_done=1 for one cycle, flush_busy=1 in this cycle, then IDLE.
- Cycle counts:
  - All clean: request accepted at cycle 0, CHECK cycles 1..256, DONE at cycle 257.
  - Each dirty line adds 4 acked WB words plus 1 CLEAN cycle.
- Index wrap: the counter never wraps past NUM_SETS-1. Termination is by comparison, not by overflow.
- Registered outputs: mem_req, mem_addr and mem_wdata are registered. arr_addr and the write strobes may be decoded from state.

Optional Feature:
- Macro: CACHE_FLUSH_INVALIDATE_EN.
- Defined: CLEAN is entered for every set with valid_rd=1, dirty or not. Clean-valid sets skip WB and go straight from CHECK to CLEAN. In CLEAN, both valid_write and dirty_write are 1. The result is an empty cache.
- Undefined: valid_write is tied 0, and only dirty lines visit CLEAN.

Decomposition:
- mem_sys_constants.v gains:
  - FLUSH_IDLE, FLUSH_CHECK, FLUSH_WB, FLUSH_CLEAN, FLUSH_DONE state encodings (3 bits).
  - FLUSH_WORDS=4.
  - Reuse of L1_NUM_SETS for NUM_SETS.
- One sub-module: flush_line_buf. It holds the 4×WORD_W + TAG_W capture register, with a load enable and a word-select read mux.

Test Plan:
- All sets invalid, flush_req pulse: mem_req is never asserted; flush_done pulses exactly 257 cycles after the request; no write strobes occur.
- Set 5 valid+dirty, tag 0x1A, data 0x1111/0x2222/0x3333/0x4444, ack every cycle: four requests at addresses 0x1A<<11 | 5<<3 | {0,2,4,6}, i.e. 0xD028, 0xD02A, 0xD02C, 0xD02E, carrying 0x1111, 0x2222, 0x3333, 0x4444. Then dirty_write for one cycle with arr_addr=5, and done at cycle 262.
- Same as the previous case but mem_ack is delayed 3 cycles per word: mem_addr and mem_wdata stay stable while unacked, and each word is sent exactly once.
- Sets 0 and 255 dirty: both are written back; index 255 is the last, followed by DONE with no wrap to 0. A flush_req pulsed while busy is ignored.
- rst asserted during WB of set 5: all outputs are 0 the next cycle, no flush_done, and set 5 keeps its dirty bit. A new flush_req restarts from index 0.
- With CACHE_FLUSH_INVALIDATE_EN defined, set 7 valid but clean: no mem_req; valid_write and dirty_write each pulse once with arr_addr=7.
